// File: rtl/ysyx_22050710_sram_arb_pkg.sv
// rtl/ysyx_22050710_sram_arb_pkg.sv - shared types, defaults and helpers for the sram-like bus arbiter
// Purpose: arbiter FSM state encodings, bus-width and channel/outstanding defaults, clog2 helper.
// Ports: none (package).
package ysyx_22050710_sram_arb_pkg;

  localparam int ARB_NUM_CH_DEF    = 2;
  localparam int ARB_MAX_OUTST_DEF = 4;
  localparam int SRAM_ADDR_WD_DEF  = 32;
  localparam int SRAM_DATA_WD_DEF  = 64;
  localparam int SRAM_WMASK_WD_DEF = SRAM_DATA_WD_DEF / 8;

  typedef enum logic [0:0] {
    YSYX_22050710_ARB_ST_IDLE   = 1'b0,
    YSYX_22050710_ARB_ST_LOCKED = 1'b1
  } arb_state_e;

  // Ceiling log2; arb_clog2(1) == 0.
  function automatic int arb_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_22050710_sram_arb_id_fifo.sv
// rtl/ysyx_22050710_sram_arb_id_fifo.sv - in-order FIFO of issuing channel IDs
// Purpose: module ysyx_22050710_id_fifo, sync FIFO remembering which channel owns each
//          outstanding downstream request, so responses can be routed back in order.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   enqueue an ID (ignored when full)
//   i_pop            dequeue the head (ignored when empty)
//   o_head           ID at the head, meaningful only when !o_empty
//   o_full, o_empty  occupancy flags
module ysyx_22050710_id_fifo
  import ysyx_22050710_sram_arb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = ARB_MAX_OUTST_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? arb_clog2(DEPTH) : 1;
  localparam int CW = arb_clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through o_head while non-empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ysyx_22050710_sram_arb.sv
// rtl/ysyx_22050710_sram_arb.sv - N-channel arbiter for the sram-like req/addr_ok/data_ok bus
// Purpose: merges upstream channels (ch0 inst, ch1 data, optional extras) onto one downstream
//          port. Grant locks until downstream accepts; an ID FIFO routes responses back in order.
// Config:  YSYX_22050710_SRAM_ARB_RR_EN defined -> round-robin; undefined -> fixed priority (ch0 first).
// Ports:
//   i_clk, i_rst_n                        clock, asynchronous active-low reset
//   i_ch_ren/wen/addr/wmask/wdata         per-channel requests, channel k at [k*W +: W]
//   o_ch_addr_ok, o_ch_data_ok            one-hot accept / response strobes
//   o_ch_rdata                            response data broadcast, valid with o_ch_data_ok
//   o_mem_ren/wen/addr/wmask/wdata        downstream request
//   i_mem_addr_ok, i_mem_data_ok, i_mem_rdata  downstream handshakes and read data
//   o_err                                 sticky: response seen with nothing outstanding
module ysyx_22050710_sram_arb
  import ysyx_22050710_sram_arb_pkg::*;
#(
  parameter int NUM_CH        = ARB_NUM_CH_DEF,
  parameter int MAX_OUTST     = ARB_MAX_OUTST_DEF,
  parameter int SRAM_ADDR_WD  = SRAM_ADDR_WD_DEF,
  parameter int SRAM_DATA_WD  = SRAM_DATA_WD_DEF,
  parameter int SRAM_WMASK_WD = SRAM_WMASK_WD_DEF
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NUM_CH-1:0]                 i_ch_ren,
  input  logic [NUM_CH-1:0]                 i_ch_wen,
  input  logic [NUM_CH*SRAM_ADDR_WD-1:0]    i_ch_addr,
  input  logic [NUM_CH*SRAM_WMASK_WD-1:0]   i_ch_wmask,
  input  logic [NUM_CH*SRAM_DATA_WD-1:0]    i_ch_wdata,
  output logic [NUM_CH-1:0]                 o_ch_addr_ok,
  output logic [NUM_CH-1:0]                 o_ch_data_ok,
  output logic [SRAM_DATA_WD-1:0]           o_ch_rdata,
  output logic                              o_mem_ren,
  output logic                              o_mem_wen,
  output logic [SRAM_ADDR_WD-1:0]           o_mem_addr,
  output logic [SRAM_WMASK_WD-1:0]          o_mem_wmask,
  output logic [SRAM_DATA_WD-1:0]           o_mem_wdata,
  input  logic                              i_mem_addr_ok,
  input  logic                              i_mem_data_ok,
  input  logic [SRAM_DATA_WD-1:0]           i_mem_rdata,
  output logic                              o_err
);

  localparam int GW = arb_clog2(NUM_CH);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [GW-1:0]    r_lock_ch;
  logic [GW-1:0]    w_pick;
  logic [GW-1:0]    w_gnt;
  logic [GW-1:0]    w_head;
  logic [NUM_CH-1:0] w_req;
  logic             w_gnt_vld;
  logic             w_accept;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             r_err;

  assign w_req = i_ch_ren | i_ch_wen;

`ifdef YSYX_22050710_SRAM_ARB_RR_EN
  logic [GW-1:0] r_rr_ptr;

  // Walk offsets from the far end so the requester closest to the pointer wins.
  always_comb begin : p_pick
    logic [GW-1:0] v_idx;
    v_idx  = '0;
    w_pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      v_idx = GW'((int'(r_rr_ptr) + i) % NUM_CH);
      if (w_req[v_idx]) w_pick = v_idx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_gnt == GW'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
    end
  end
`else
  always_comb begin : p_pick
    logic [GW-1:0] v_idx;
    v_idx  = '0;
    w_pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      v_idx = GW'(i);
      if (w_req[v_idx]) w_pick = v_idx;
    end
  end
`endif

  // Full blocks new grants even when a response pops this cycle, keeping
  // data_ok out of the combinational request path.
  assign w_gnt_vld = i_rst_n & ((r_state == YSYX_22050710_ARB_ST_LOCKED) | ((|w_req) & ~w_full));
  assign w_gnt     = (r_state == YSYX_22050710_ARB_ST_LOCKED) ? r_lock_ch : w_pick;

  assign o_mem_ren   = w_gnt_vld & i_ch_ren[w_gnt];
  assign o_mem_wen   = w_gnt_vld & i_ch_wen[w_gnt];
  assign o_mem_addr  = w_gnt_vld ? i_ch_addr[int'(w_gnt)*SRAM_ADDR_WD +: SRAM_ADDR_WD] : '0;
  assign o_mem_wmask = w_gnt_vld ? i_ch_wmask[int'(w_gnt)*SRAM_WMASK_WD +: SRAM_WMASK_WD] : '0;
  assign o_mem_wdata = w_gnt_vld ? i_ch_wdata[int'(w_gnt)*SRAM_DATA_WD +: SRAM_DATA_WD] : '0;

  assign w_accept     = (o_mem_ren | o_mem_wen) & i_mem_addr_ok;
  assign o_ch_addr_ok = w_accept ? (NUM_CH'(1) << w_gnt) : '0;

  assign w_pop        = i_rst_n & i_mem_data_ok & ~w_empty;
  assign o_ch_data_ok = w_pop ? (NUM_CH'(1) << w_head) : '0;
  assign o_ch_rdata   = w_pop ? i_mem_rdata : '0;
  assign o_err        = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= YSYX_22050710_ARB_ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      YSYX_22050710_ARB_ST_IDLE:
        if (w_gnt_vld && !i_mem_addr_ok) w_state_nxt = YSYX_22050710_ARB_ST_LOCKED;
      YSYX_22050710_ARB_ST_LOCKED:
        if (i_mem_addr_ok) w_state_nxt = YSYX_22050710_ARB_ST_IDLE;
      default:
        w_state_nxt = YSYX_22050710_ARB_ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_ch <= '0;
    end else if (r_state == YSYX_22050710_ARB_ST_IDLE && w_gnt_vld && !i_mem_addr_ok) begin
      r_lock_ch <= w_pick;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_err <= 1'b0;
    else if (i_mem_data_ok && w_empty) r_err <= 1'b1;
  end

  ysyx_22050710_id_fifo #(
    .WIDTH (GW),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_accept),
    .i_data  (w_gnt),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_ysyx_22050710_sram_arb.sv
// tb/tb_ysyx_22050710_sram_arb.sv - self-checking bench for ysyx_22050710_sram_arb
module tb_ysyx_22050710_sram_arb;

  localparam int N  = 2;
  localparam int M  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = 8;
`ifdef YSYX_22050710_SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_rst_n;
  logic [N-1:0]    i_ch_ren, i_ch_wen;
  logic [N*AW-1:0] i_ch_addr;
  logic [N*MW-1:0] i_ch_wmask;
  logic [N*DW-1:0] i_ch_wdata;
  logic [N-1:0]    o_ch_addr_ok, o_ch_data_ok;
  logic [DW-1:0]   o_ch_rdata;
  logic            o_mem_ren, o_mem_wen;
  logic [AW-1:0]   o_mem_addr;
  logic [MW-1:0]   o_mem_wmask;
  logic [DW-1:0]   o_mem_wdata;
  logic            i_mem_addr_ok, i_mem_data_ok;
  logic [DW-1:0]   i_mem_rdata;
  logic            o_err;

  ysyx_22050710_sram_arb dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_ch_ren(i_ch_ren), .i_ch_wen(i_ch_wen), .i_ch_addr(i_ch_addr),
    .i_ch_wmask(i_ch_wmask), .i_ch_wdata(i_ch_wdata),
    .o_ch_addr_ok(o_ch_addr_ok), .o_ch_data_ok(o_ch_data_ok), .o_ch_rdata(o_ch_rdata),
    .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wmask(o_mem_wmask), .o_mem_wdata(o_mem_wdata),
    .i_mem_addr_ok(i_mem_addr_ok), .i_mem_data_ok(i_mem_data_ok),
    .i_mem_rdata(i_mem_rdata), .o_err(o_err)
  );

  // Stimulus shadows, applied at the next falling edge.
  logic            s_rst_n;
  logic [N-1:0]    s_ren, s_wen;
  logic [N*AW-1:0] s_addr;
  logic [N*MW-1:0] s_wmask;
  logic [N*DW-1:0] s_wdata;
  logic            s_aok, s_dok;
  logic [DW-1:0]   s_rdata;

  // Reference model: lock owner (-1 none), queue of outstanding owners, rr pointer, sticky error.
  int m_lock;
  int m_q[$];
  int m_rr;
  bit m_err;
  logic [N-1:0] l_aok;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = -1;
    m_q.delete();
    m_rr   = 0;
    m_err  = 1'b0;
  endtask

  task automatic idle_in();
    s_rst_n = 1'b1; s_ren = '0; s_wen = '0; s_addr = '0; s_wmask = '0; s_wdata = '0;
    s_aok = 1'b0; s_dok = 1'b0; s_rdata = '0;
  endtask

  // One clock: apply shadows, compare every output against the model, advance the model.
  task automatic step();
    int g;
    bit vld, acc, pop;
    logic [N-1:0] req;
    logic e_ren, e_wen;
    logic [AW-1:0] e_addr;
    logic [MW-1:0] e_wmask;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [N-1:0] e_aok, e_dok;
    @(negedge clk);
    i_rst_n = s_rst_n; i_ch_ren = s_ren; i_ch_wen = s_wen; i_ch_addr = s_addr;
    i_ch_wmask = s_wmask; i_ch_wdata = s_wdata; i_mem_addr_ok = s_aok;
    i_mem_data_ok = s_dok; i_mem_rdata = s_rdata;
    #1;
    req = s_ren | s_wen;
    g = 0; vld = 1'b0;
    if (!s_rst_n) begin
      vld = 1'b0;
    end else if (m_lock >= 0) begin
      g = m_lock; vld = 1'b1;
    end else if (req != '0 && m_q.size() < M) begin
      vld = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
        int c;
        c = RR ? (m_rr + i) % N : i;
        if (req[c]) g = c;
      end
    end
    e_ren   = vld & s_ren[g];
    e_wen   = vld & s_wen[g];
    e_addr  = vld ? s_addr[g*AW +: AW] : '0;
    e_wmask = vld ? s_wmask[g*MW +: MW] : '0;
    e_wdata = vld ? s_wdata[g*DW +: DW] : '0;
    acc     = (e_ren | e_wen) & s_aok;
    e_aok   = acc ? N'(1 << g) : '0;
    pop     = s_rst_n && s_dok && m_q.size() > 0;
    e_dok   = pop ? N'(1 << m_q[0]) : '0;
    e_rdata = pop ? s_rdata : '0;
    chk("mem_ren", 64'(o_mem_ren), 64'(e_ren));
    chk("mem_wen", 64'(o_mem_wen), 64'(e_wen));
    chk("mem_addr", 64'(o_mem_addr), 64'(e_addr));
    chk("mem_wmask", 64'(o_mem_wmask), 64'(e_wmask));
    chk("mem_wdata", o_mem_wdata, e_wdata);
    chk("ch_addr_ok", 64'(o_ch_addr_ok), 64'(e_aok));
    chk("ch_data_ok", 64'(o_ch_data_ok), 64'(e_dok));
    chk("ch_rdata", o_ch_rdata, e_rdata);
    chk("err", 64'(o_err), (s_rst_n ? 64'(m_err) : 64'h0));
    l_aok = e_aok;
    if (!s_rst_n) begin
      model_reset();
    end else begin
      if (s_dok && m_q.size() == 0) m_err = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(g);
        m_rr   = (g + 1) % N;
        m_lock = -1;
      end else if (vld) begin
        m_lock = g;
      end
    end
  endtask

  task automatic do_reset();
    idle_in();
    s_rst_n = 1'b0;
    s_ren = 2'b11; s_aok = 1'b1; s_dok = 1'b1; s_rdata = 64'h55;
    step();
    step();
    idle_in();
    step();
    chk("post_reset_err", 64'(o_err), 64'h0);
  endtask

  bit pend[N];

  initial begin
    i_rst_n = 1'b0; i_ch_ren = '0; i_ch_wen = '0; i_ch_addr = '0; i_ch_wmask = '0;
    i_ch_wdata = '0; i_mem_addr_ok = 1'b0; i_mem_data_ok = 1'b0; i_mem_rdata = '0;
    model_reset();
    l_aok = '0;
    do_reset();

    // 1: single read, response next cycle
    idle_in();
    s_ren = 2'b01; s_addr[31:0] = 32'h8000_0000; s_aok = 1'b1;
    step();
    chk("t1_addr_ok", 64'(o_ch_addr_ok), 64'h1);
    chk("t1_mem_addr", 64'(o_mem_addr), 64'h8000_0000);
    idle_in();
    s_dok = 1'b1; s_rdata = 64'hDEAD;
    step();
    chk("t1_data_ok", 64'(o_ch_data_ok), 64'h1);
    chk("t1_rdata", o_ch_rdata, 64'hDEAD);

    // 2: both channels request continuously
    do_reset();
    s_ren = 2'b11; s_aok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_grant", 64'(o_ch_addr_ok), (RR && (k % 2 == 1)) ? 64'h2 : 64'h1);
    end

    // 3: lock holds ch1 while downstream stalls
    do_reset();
    s_wen = 2'b10; s_addr[63:32] = 32'h1000_0040; s_wmask[15:8] = 8'h0F;
    s_wdata[127:64] = 64'h0123_4567_89AB_CDEF;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin s_ren[0] = 1'b1; s_addr[31:0] = 32'h2000; end
      step();
      chk("t3_wen", 64'(o_mem_wen), 64'h1);
      chk("t3_addr", 64'(o_mem_addr), 64'h1000_0040);
      chk("t3_no_ack", 64'(o_ch_addr_ok), 64'h0);
    end
    s_aok = 1'b1;
    step();
    chk("t3_ch1_ack", 64'(o_ch_addr_ok), 64'h2);
    s_wen = '0;
    step();
    chk("t3_ch0_ack", 64'(o_ch_addr_ok), 64'h1);
    chk("t3_ch0_addr", 64'(o_mem_addr), 64'h2000);

    // 4: full FIFO blocks issue, including the cycle a response pops
    do_reset();
    s_ren = 2'b01; s_aok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_addr[31:0] = 32'h100 + 32'(k * 8);
      step();
      chk("t4_fill", 64'(o_ch_addr_ok), 64'h1);
    end
    step();
    chk("t4_full_ren", 64'(o_mem_ren), 64'h0);
    s_dok = 1'b1; s_rdata = 64'h7;
    step();
    chk("t4_pop_ren", 64'(o_mem_ren), 64'h0);
    chk("t4_pop_dok", 64'(o_ch_data_ok), 64'h1);
    s_dok = 1'b0;
    step();
    chk("t4_issue", 64'(o_ch_addr_ok), 64'h1);

    // 5: in-order response routing
    do_reset();
    s_aok = 1'b1;
    s_ren = 2'b10; step(); chk("t5_a0", 64'(o_ch_addr_ok), 64'h2);
    s_ren = 2'b01; step(); chk("t5_a1", 64'(o_ch_addr_ok), 64'h1);
    s_ren = 2'b10; step(); chk("t5_a2", 64'(o_ch_addr_ok), 64'h2);
    s_ren = '0; s_aok = 1'b0; s_dok = 1'b1;
    s_rdata = 64'd1; step(); chk("t5_r1", 64'(o_ch_data_ok), 64'h2); chk("t5_d1", o_ch_rdata, 64'd1);
    s_rdata = 64'd2; step(); chk("t5_r2", 64'(o_ch_data_ok), 64'h1); chk("t5_d2", o_ch_rdata, 64'd2);
    s_rdata = 64'd3; step(); chk("t5_r3", 64'(o_ch_data_ok), 64'h2); chk("t5_d3", o_ch_rdata, 64'd3);

    // 6: stray response sets sticky error
    do_reset();
    s_dok = 1'b1; s_rdata = 64'h5;
    step();
    chk("t6_no_dok", 64'(o_ch_data_ok), 64'h0);
    s_dok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_err", 64'(o_err), 64'h1);
    end
    do_reset();

    // Random traffic against the model
    idle_in();
    for (int c = 0; c < N; c++) pend[c] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (pend[c] && l_aok[c]) pend[c] = 1'b0;
        if (!pend[c]) begin
          s_addr[c*AW +: AW]  = $urandom;
          s_wmask[c*MW +: MW] = MW'($urandom);
          s_wdata[c*DW +: DW] = {$urandom, $urandom};
          s_ren[c] = 1'b0;
          s_wen[c] = 1'b0;
          if ($urandom_range(0, 2) == 0) begin
            pend[c] = 1'b1;
            if ($urandom_range(0, 1) == 0) s_ren[c] = 1'b1;
            else                           s_wen[c] = 1'b1;
          end
        end
      end
      s_aok   = ($urandom_range(0, 2) != 0);
      s_dok   = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 299) == 0);
      s_rdata = {$urandom, $urandom};
      s_rst_n = !(cyc % 1000 == 999);
      step();
      if (!s_rst_n) begin
        s_rst_n = 1'b1;
        s_aok = 1'b0; s_dok = 1'b0;
        for (int c = 0; c < N; c++) pend[c] = 1'b0;
        s_ren = '0; s_wen = '0;
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
